// File: rtl/timetag_pkg.sv
// Shared constants and types for the timetag record serializer.
// Used by record_serializer, its interface and the bench.
package timetag_pkg;

    localparam logic [7:0] SYNC_BYTE = 8'hA5;
    localparam int RECORD_BYTES_DEFAULT = 6;
    localparam int FIFO_DEPTH_DEFAULT = 16;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SYNC  = 2'd1,
        SHIFT = 2'd2
    } ser_state_t;

endpackage

// File: rtl/record_serializer_if.sv
// Record input strobe, byte handshake towards ft2232 and status.
// slave = serializer side, master = driver/host side.
interface record_serializer_if #(
    parameter int RECORD_BYTES = 6,
    parameter int FIFO_DEPTH = 16
);

    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    logic [8*RECORD_BYTES-1:0] record_i;
    logic                      record_stb_i;
    logic [7:0]                out_data_o;
    logic                      out_req_o;
    logic                      out_ack_i;
    logic [CW-1:0]             fifo_count_o;
    logic                      overflow_o;
    logic                      overflow_clr_i;

    modport slave (
        input  record_i,
        input  record_stb_i,
        input  out_ack_i,
        input  overflow_clr_i,
        output out_data_o,
        output out_req_o,
        output fifo_count_o,
        output overflow_o
    );

    modport master (
        output record_i,
        output record_stb_i,
        output out_ack_i,
        output overflow_clr_i,
        input  out_data_o,
        input  out_req_o,
        input  fifo_count_o,
        input  overflow_o
    );

endinterface

// File: rtl/sync_fifo.sv
// Single-clock first-word-fall-through FIFO with occupancy count.
// A write while full is accepted when a read happens in the same cycle.
module sync_fifo #(
    parameter int WIDTH = 48,
    parameter int DEPTH = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   wr_en,
    input  logic [WIDTH-1:0]       wr_data,
    input  logic                   rd_en,
    output logic [WIDTH-1:0]       rd_data,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      cnt;
    logic             do_wr;
    logic             do_rd;

    assign full    = (cnt == (AW+1)'(DEPTH));
    assign empty   = (cnt == '0);
    assign do_rd   = rd_en && !empty;
    assign do_wr   = wr_en && (!full || do_rd);
    assign rd_data = mem[rd_ptr];
    assign count   = cnt;

    // Storage array; contents need no reset.
    always_ff @(posedge clk) begin
        if (do_wr) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    // Pointers wrap naturally; occupancy kept in its own register.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (do_wr) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (do_rd) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            unique case ({do_wr, do_rd})
                2'b10:   cnt <= cnt + (AW+1)'(1);
                2'b01:   cnt <= cnt - (AW+1)'(1);
                default: cnt <= cnt;
            endcase
        end
    end

endmodule

// File: rtl/record_serializer.sv
// Buffers timetag records and streams them MSB byte first to ft2232.
// Define RECORD_SYNC_EN to prefix every record with SYNC_BYTE.
module record_serializer
    import timetag_pkg::*;
#(
    parameter int RECORD_BYTES = RECORD_BYTES_DEFAULT,
    parameter int FIFO_DEPTH = FIFO_DEPTH_DEFAULT
) (
    input logic clk_i,
    input logic reset_i,
    record_serializer_if.slave bus
);

    localparam int RW = 8 * RECORD_BYTES;
    localparam int IDX_W = (RECORD_BYTES > 1) ? $clog2(RECORD_BYTES) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(RECORD_BYTES - 1);
`ifdef RECORD_SYNC_EN
    localparam ser_state_t FIRST = SYNC;
`else
    localparam ser_state_t FIRST = SHIFT;
`endif

    ser_state_t       state;
    ser_state_t       state_n;
    logic [RW-1:0]    shreg;
    logic [RW-1:0]    shreg_n;
    logic [IDX_W-1:0] idx;
    logic [IDX_W-1:0] idx_n;
    logic [RW-1:0]    head;
    logic             fifo_full;
    logic             fifo_empty;
    logic             pop;
    logic             drop;
    logic             overflow;
    logic [7:0]       out_data;
    logic             out_req;

    sync_fifo #(
        .WIDTH(RW),
        .DEPTH(FIFO_DEPTH)
    ) u_fifo (
        .clk    (clk_i),
        .reset  (reset_i),
        .wr_en  (bus.record_stb_i),
        .wr_data(bus.record_i),
        .rd_en  (pop),
        .rd_data(head),
        .full   (fifo_full),
        .empty  (fifo_empty),
        .count  (bus.fifo_count_o)
    );

    // Detectors cannot stall: a strobe with no room this cycle is lost.
    assign drop = bus.record_stb_i && fifo_full && !pop;

    // Sticky overflow flag; a new drop wins over a clear.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            overflow <= 1'b0;
        end else if (drop) begin
            overflow <= 1'b1;
        end else if (bus.overflow_clr_i) begin
            overflow <= 1'b0;
        end
    end

    // Serializer state, record shadow and byte index.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state <= IDLE;
            shreg <= '0;
            idx   <= '0;
        end else begin
            state <= state_n;
            shreg <= shreg_n;
            idx   <= idx_n;
        end
    end

    // Next state, FIFO pop and byte presented to ft2232.
    always_comb begin
        state_n  = state;
        shreg_n  = shreg;
        idx_n    = idx;
        pop      = 1'b0;
        out_data = 8'h00;
        out_req  = 1'b0;
        unique case (state)
            IDLE: begin
                if (!fifo_empty) begin
                    pop     = 1'b1;
                    shreg_n = head;
                    idx_n   = LAST_IDX;
                    state_n = FIRST;
                end
            end
`ifdef RECORD_SYNC_EN
            SYNC: begin
                out_data = SYNC_BYTE;
                out_req  = 1'b1;
                if (bus.out_ack_i) begin
                    state_n = SHIFT;
                end
            end
`endif
            SHIFT: begin
                out_data = shreg[8*idx +: 8];
                out_req  = 1'b1;
                if (bus.out_ack_i) begin
                    if (idx != '0) begin
                        idx_n = idx - IDX_W'(1);
                    end else if (!fifo_empty) begin
                        pop     = 1'b1;
                        shreg_n = head;
                        idx_n   = LAST_IDX;
                        state_n = FIRST;
                    end else begin
                        state_n = IDLE;
                    end
                end
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    assign bus.out_data_o = out_data;
    assign bus.out_req_o  = out_req;
    assign bus.overflow_o = overflow;

endmodule

// File: tb/tb_record_serializer.sv
// Directed bench for record_serializer: latency, byte order, FIFO fill,
// overflow, full-with-pop, reset mid-record, optional sync byte.
module tb_record_serializer;

    typedef logic [7:0] bytes_t [6];

    typedef struct {
        string         name;
        logic [47:0]   rec;
        bytes_t        ex;
    } vec_t;

    logic clk;
    logic rst;
    int   checks;
    int   errors;

    record_serializer_if #(.RECORD_BYTES(6), .FIFO_DEPTH(16)) bus ();

    record_serializer #(
        .RECORD_BYTES(6),
        .FIFO_DEPTH(16)
    ) dut (
        .clk_i  (clk),
        .reset_i(rst),
        .bus    (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0h want %0h", nm, act, exp);
        end
    endtask

    task automatic ack_one();
        bus.out_ack_i = 1'b1;
        tick();
        bus.out_ack_i = 1'b0;
    endtask

    task automatic wait_req(input string nm, output int w);
        w = 0;
        while (!bus.out_req_o && w < 20) begin
            tick();
            w++;
        end
        if (!bus.out_req_o) begin
            checks++;
            errors++;
            $display("FAIL %s req timeout got 0 want 1", nm);
        end
    endtask

    task automatic strobe(input logic [47:0] rec);
        bus.record_i     = rec;
        bus.record_stb_i = 1'b1;
        tick();
        bus.record_stb_i = 1'b0;
    endtask

    task automatic take_bytes(input string nm, input bytes_t ex,
                              input bit stb_last, input logic [47:0] nrec,
                              output int waits);
        int w;
        waits = 0;
`ifdef RECORD_SYNC_EN
        wait_req(nm, w);
        waits += w;
        chk({nm, " sync"}, 32'(bus.out_data_o), 32'h A5);
        ack_one();
`endif
        for (int i = 0; i < 6; i++) begin
            wait_req(nm, w);
            waits += w;
            chk($sformatf("%s b%0d", nm, i), 32'(bus.out_data_o), 32'(ex[i]));
            if (stb_last && i == 5) begin
                bus.record_i     = nrec;
                bus.record_stb_i = 1'b1;
            end
            ack_one();
            bus.record_stb_i = 1'b0;
        end
    endtask

    function automatic bytes_t rep(input logic [7:0] b);
        bytes_t r;
        for (int i = 0; i < 6; i++) r[i] = b;
        return r;
    endfunction

    initial begin
        vec_t        vecs [4];
        int          waits;
        logic [7:0]  bv;
        logic [7:0]  first;

        checks = 0;
        errors = 0;

        vecs[0] = '{"v0102", 48'h0102_0304_0506,
                    '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06}};
        vecs[1] = '{"vaabb", 48'hAABB_CCDD_EEFF,
                    '{8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'hEE, 8'hFF}};
        vecs[2] = '{"v0a0b", 48'h0A0B_0C0D_0E0F,
                    '{8'h0A, 8'h0B, 8'h0C, 8'h0D, 8'h0E, 8'h0F}};
        vecs[3] = '{"vff00", 48'hFF00_8001_7F5A,
                    '{8'hFF, 8'h00, 8'h80, 8'h01, 8'h7F, 8'h5A}};

        rst                = 1'b1;
        bus.record_i       = '0;
        bus.record_stb_i   = 1'b0;
        bus.out_ack_i      = 1'b0;
        bus.overflow_clr_i = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        chk("rst req", 32'(bus.out_req_o), 0);
        chk("rst data", 32'(bus.out_data_o), 0);
        chk("rst count", 32'(bus.fifo_count_o), 0);
        chk("rst ovf", 32'(bus.overflow_o), 0);

        // Latency and byte order of a single record.
        strobe(vecs[0].rec);
        chk("lat c1 req", 32'(bus.out_req_o), 0);
        tick();
        chk("lat c2 req", 32'(bus.out_req_o), 1);
        take_bytes("t1", vecs[0].ex, 1'b0, '0, waits);
        chk("t1 waits", 32'(waits), 0);
        chk("t1 req low", 32'(bus.out_req_o), 0);
        chk("t1 count", 32'(bus.fifo_count_o), 0);

        // Fill: 17 strobes, no acks.
        for (int k = 0; k < 17; k++) begin
            bv = 8'(16 + k);
            bus.record_i     = {6{bv}};
            bus.record_stb_i = 1'b1;
            tick();
        end
        bus.record_stb_i = 1'b0;
`ifdef RECORD_SYNC_EN
        first = 8'hA5;
`else
        first = 8'h10;
`endif
        chk("t2 count", 32'(bus.fifo_count_o), 16);
        chk("t2 ovf", 32'(bus.overflow_o), 0);
        chk("t2 req", 32'(bus.out_req_o), 1);
        chk("t2 data", 32'(bus.out_data_o), 32'(first));
        tick();
        tick();
        chk("t2 data hold", 32'(bus.out_data_o), 32'(first));
        strobe(48'hDEAD_DEAD_DEAD);
        chk("t2 drop ovf", 32'(bus.overflow_o), 1);
        chk("t2 drop count", 32'(bus.fifo_count_o), 16);

        bus.overflow_clr_i = 1'b1;
        tick();
        bus.overflow_clr_i = 1'b0;
        chk("clr ovf", 32'(bus.overflow_o), 0);

        // Full FIFO, strobe coincident with last-byte ack.
        take_bytes("t3", rep(8'h10), 1'b1, {6{8'hEE}}, waits);
        chk("t3 waits", 32'(waits), 0);
        chk("t3 count", 32'(bus.fifo_count_o), 16);
        chk("t3 ovf", 32'(bus.overflow_o), 0);
        chk("t3 req", 32'(bus.out_req_o), 1);
`ifdef RECORD_SYNC_EN
        first = 8'hA5;
`else
        first = 8'h11;
`endif
        chk("t3 next", 32'(bus.out_data_o), 32'(first));

        // Overflow set beats clear.
        strobe(48'h1234_5678_9ABC);
        chk("t5 ovf set", 32'(bus.overflow_o), 1);
        bus.overflow_clr_i = 1'b1;
        strobe(48'h1234_5678_9ABC);
        chk("t5 set wins", 32'(bus.overflow_o), 1);
        tick();
        bus.overflow_clr_i = 1'b0;
        chk("t5 clr", 32'(bus.overflow_o), 0);
        chk("t5 count", 32'(bus.fifo_count_o), 16);

        // Reset in the middle of a record.
        for (int i = 0; i < 3; i++) ack_one();
        rst = 1'b1;
        tick();
        chk("t4 req", 32'(bus.out_req_o), 0);
        chk("t4 count", 32'(bus.fifo_count_o), 0);
        chk("t4 data", 32'(bus.out_data_o), 0);
        rst = 1'b0;
        tick();

        // Ack with no request pending has no effect.
        ack_one();
        chk("idle ack req", 32'(bus.out_req_o), 0);
        chk("idle ack count", 32'(bus.fifo_count_o), 0);

        for (int v = 0; v < 4; v++) begin
            strobe(vecs[v].rec);
            take_bytes(vecs[v].name, vecs[v].ex, 1'b0, '0, waits);
            chk({vecs[v].name, " req low"}, 32'(bus.out_req_o), 0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
